axi_lite_cmd_master: RTL and testbench

//  Single-outstanding AXI4-Lite initiator. Turns a simple command/response handshake into AXI-Lite

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/axi_lite_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and command-master FSM encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WADDR_DATA = 3'd1;
  localparam logic [2:0] ST_WRESP      = 3'd2;
  localparam logic [2:0] ST_RADDR      = 3'd3;
  localparam logic [2:0] ST_RDATA      = 3'd4;
  localparam logic [2:0] ST_RSP        = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    WADDR_DATA = ST_WADDR_DATA,
    WRESP      = ST_WRESP,
    RADDR      = ST_RADDR,
    RDATA      = ST_RDATA,
    RSP        = ST_RSP
  } state_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a command/response handshake.
// Optional watchdog enabled by defining AXI_LITE_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [STROBE_WIDTH-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp
);

  state_t                  state;
  state_t                  state_next;
  logic                    started;
  logic                    aw_done;
  logic                    w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STROBE_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic                    timeout;
  logic                    cmd_fire;
  logic                    aw_fire;
  logic                    w_fire;

  // started keeps cmd_ready low during the reset cycle so every output reads 0
  assign o_cmd_ready = (state == IDLE) && started;
  assign o_awvalid   = (state == WADDR_DATA) && !aw_done;
  assign o_wvalid    = (state == WADDR_DATA) && !w_done;
  assign o_bready    = (state == WRESP);
  assign o_arvalid   = (state == RADDR);
  assign o_rready    = (state == RDATA);
  assign o_rsp_valid = (state == RSP);
  assign o_awaddr    = addr_q;
  assign o_araddr    = addr_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;

  assign cmd_fire = i_cmd_valid && o_cmd_ready;
  assign aw_fire  = o_awvalid && i_awready;
  assign w_fire   = o_wvalid && i_wready;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting = (state != IDLE) && (state != RSP);
  assign timeout = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      wait_cnt <= '0;
    end else if (cmd_fire) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  // Timeout wins over address handshakes but a B/R beat in the same cycle still completes
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_fire) state_next = i_cmd_wr ? WADDR_DATA : RADDR;
      end
      WADDR_DATA: begin
        if (timeout) state_next = RSP;
        else if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WRESP;
      end
      WRESP: begin
        if (i_bvalid || timeout) state_next = RSP;
      end
      RADDR: begin
        if (timeout) state_next = RSP;
        else if (i_arready) state_next = RDATA;
      end
      RDATA: begin
        if (i_rvalid || timeout) state_next = RSP;
      end
      RSP: begin
        if (i_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q  <= i_cmd_addr;
        wdata_q <= i_cmd_wdata;
        wstrb_q <= i_cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire) w_done <= 1'b1;
      if ((state == WRESP) && i_bvalid) begin
        rdata_q <= '0;
        resp_q  <= i_bresp;
      end else if ((state == RDATA) && i_rvalid) begin
        rdata_q <= i_rdata;
        resp_q  <= i_rresp;
      end else if (timeout) begin
        rdata_q <= '0;
        resp_q  <= RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed commands, a delay-configurable slave and a transaction-level model.
module tb_axi_lite_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          i_axi_clk   = 1'b0;
  logic          i_axi_rst   = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic          i_cmd_wr    = 1'b0;
  logic [AW-1:0] i_cmd_addr  = '0;
  logic [DW-1:0] i_cmd_wdata = '0;
  logic [SW-1:0] i_cmd_wstrb = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b1;
  logic [DW-1:0] o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic          o_awvalid;
  logic          i_awready   = 1'b0;
  logic [AW-1:0] o_awaddr;
  logic          o_wvalid;
  logic          i_wready    = 1'b0;
  logic [DW-1:0] o_wdata;
  logic [SW-1:0] o_wstrb;
  logic          i_bvalid    = 1'b0;
  logic          o_bready;
  logic [1:0]    i_bresp     = 2'b00;
  logic          o_arvalid;
  logic          i_arready   = 1'b0;
  logic [AW-1:0] o_araddr;
  logic          i_rvalid    = 1'b0;
  logic          o_rready;
  logic [DW-1:0] i_rdata     = '0;
  logic [1:0]    i_rresp     = 2'b00;

  axi_lite_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_axi_clk(i_axi_clk), .i_axi_rst(i_axi_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
  );

  always #5 i_axi_clk = ~i_axi_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge i_axi_clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  // Slave: each ready/valid answers after a configurable number of cycles of the master's request
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  always @(posedge i_axi_clk) begin
    #1;
    if (o_awvalid) begin i_awready = (aw_cnt >= aw_delay); aw_cnt++; end
    else begin i_awready = 1'b0; aw_cnt = 0; end
    if (o_wvalid) begin i_wready = (w_cnt >= w_delay); w_cnt++; end
    else begin i_wready = 1'b0; w_cnt = 0; end
    if (o_arvalid) begin i_arready = (ar_cnt >= ar_delay); ar_cnt++; end
    else begin i_arready = 1'b0; ar_cnt = 0; end
    if (o_bready) begin i_bvalid = (b_cnt >= b_delay); i_bresp = bresp_cfg; b_cnt++; end
    else begin i_bvalid = 1'b0; i_bresp = 2'b00; b_cnt = 0; end
    if (o_rready) begin
      i_rvalid = (r_cnt >= r_delay); i_rdata = rdata_cfg; i_rresp = rresp_cfg; r_cnt++;
    end else begin
      i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00; r_cnt = 0;
    end
  end

  // Model: one outstanding command, tracked as which of its handshakes have happened
  logic        model_en = 1'b0;
  logic        m_reset_seen = 1'b1;
  logic        m_busy = 1'b0, m_wr = 1'b0, m_aw_done = 1'b0, m_w_done = 1'b0, m_ar_done = 1'b0;
  logic        m_rsp_pend = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rsp_data = '0;
  logic [3:0]  m_wstrb = '0;
  logic [1:0]  m_rsp_resp = 2'b00;
  int          m_wait = 0;

  always @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      model_en = 1'b1; m_reset_seen = 1'b1; m_busy = 1'b0; m_rsp_pend = 1'b0;
      m_aw_done = 1'b0; m_w_done = 1'b0; m_ar_done = 1'b0; m_rsp_data = '0; m_rsp_resp = 2'b00;
    end else if (model_en) begin
      if (m_rsp_pend) begin
        if (i_rsp_ready) m_rsp_pend = 1'b0;
      end else if (m_busy) begin
        if (m_wr && m_aw_done && m_w_done && i_bvalid) begin
          m_busy = 1'b0; m_rsp_pend = 1'b1; m_rsp_data = '0; m_rsp_resp = i_bresp;
        end else if (!m_wr && m_ar_done && i_rvalid) begin
          m_busy = 1'b0; m_rsp_pend = 1'b1; m_rsp_data = i_rdata; m_rsp_resp = i_rresp;
        end
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
        else if (m_wait == TO - 1) begin
          m_busy = 1'b0; m_rsp_pend = 1'b1; m_rsp_data = '0; m_rsp_resp = 2'b10;
        end
`endif
        else begin
          m_wait++;
          if (m_wr) begin
            if (!m_aw_done && i_awready) m_aw_done = 1'b1;
            if (!m_w_done && i_wready) m_w_done = 1'b1;
          end else if (!m_ar_done && i_arready) begin
            m_ar_done = 1'b1;
          end
        end
      end else if (!m_reset_seen && i_cmd_valid) begin
        m_busy = 1'b1; m_wr = i_cmd_wr; m_addr = i_cmd_addr; m_wdata = i_cmd_wdata;
        m_wstrb = i_cmd_wstrb; m_aw_done = 1'b0; m_w_done = 1'b0; m_ar_done = 1'b0; m_wait = 0;
      end
      m_reset_seen = 1'b0;
    end
  end

  always @(negedge i_axi_clk) begin
    if (model_en) begin
      if (m_reset_seen) begin
        check_output("reset_all_zero", 64'(|{o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp,
                     o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready, o_arvalid,
                     o_araddr, o_rready}), 64'd0);
      end else begin
        check_output("cmd_ready", 64'(o_cmd_ready), 64'(!m_busy && !m_rsp_pend));
        check_output("awvalid", 64'(o_awvalid), 64'(m_busy && m_wr && !m_aw_done));
        check_output("wvalid", 64'(o_wvalid), 64'(m_busy && m_wr && !m_w_done));
        check_output("bready", 64'(o_bready), 64'(m_busy && m_wr && m_aw_done && m_w_done));
        check_output("arvalid", 64'(o_arvalid), 64'(m_busy && !m_wr && !m_ar_done));
        check_output("rready", 64'(o_rready), 64'(m_busy && !m_wr && m_ar_done));
        check_output("rsp_valid", 64'(o_rsp_valid), 64'(m_rsp_pend));
        if (m_busy && m_wr && !m_aw_done) check_output("awaddr", 64'(o_awaddr), 64'(m_addr));
        if (m_busy && m_wr && !m_w_done) begin
          check_output("wdata", 64'(o_wdata), 64'(m_wdata));
          check_output("wstrb", 64'(o_wstrb), 64'(m_wstrb));
        end
        if (m_busy && !m_wr && !m_ar_done) check_output("araddr", 64'(o_araddr), 64'(m_addr));
        if (m_rsp_pend) begin
          check_output("rsp_rdata", 64'(o_rsp_rdata), 64'(m_rsp_data));
          check_output("rsp_resp", 64'(o_rsp_resp), 64'(m_rsp_resp));
        end
      end
    end
  end

  task automatic step();
    @(posedge i_axi_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb);
    i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = wdata; i_cmd_wstrb = strb; i_cmd_valid = 1'b1;
  endtask

  task automatic wait_capture(output int cap);
    logic rdy;
    cap = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_axi_clk);
      rdy = o_cmd_ready;
      step();
      if (rdy) begin
        i_cmd_valid = 1'b0;
        cap = cyc;
        return;
      end
    end
    check_output("capture_bound", 64'd1, 64'd0);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int rc);
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_axi_clk);
      if (o_rsp_valid) begin
        rc = cyc;
        return;
      end
    end
    check_output("rsp_bound", 64'd1, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit actual=running required=finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int cap, r;
    repeat (2) @(negedge i_axi_clk);
    check_output("t0_reset_cmd_ready", 64'(o_cmd_ready), 64'd0);
    step();
    i_axi_rst = 1'b1;
    step();
    @(negedge i_axi_clk);
    check_output("t0_ready_after_reset", 64'(o_cmd_ready), 64'd1);
    step();

    $display("[TB] test 1: write, slave always ready");
    apply_stimulus(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
    wait_capture(cap);
    @(negedge i_axi_clk);
    check_output("t1_aw_w_together", 64'({o_awvalid, o_wvalid}), 64'd3);
    check_output("t1_awaddr", 64'(o_awaddr), 64'h10);
    wait_rsp(20, r);
    check_output("t1_rsp_latency", 64'(r - cap), 64'd2);
    check_output("t1_resp", 64'(o_rsp_resp), 64'd0);
    check_output("t1_rdata", 64'(o_rsp_rdata), 64'd0);
    step();

    $display("[TB] test 2: write, awready 3 cycles after wready");
    aw_delay = 3;
    apply_stimulus(1'b1, 32'h20, 32'h12345678, 4'h3);
    wait_capture(cap);
    @(negedge i_axi_clk);
    check_output("t2_both_valid", 64'({o_awvalid, o_wvalid}), 64'd3);
    step();
    @(negedge i_axi_clk);
    check_output("t2_w_dropped_aw_held", 64'({o_awvalid, o_wvalid}), 64'd2);
    wait_rsp(20, r);
    check_output("t2_rsp_latency", 64'(r - cap), 64'd5);
    step();
    @(negedge i_axi_clk);
    check_output("t2_single_rsp", 64'(o_rsp_valid), 64'd0);
    aw_delay = 0;
    step();

    $display("[TB] test 3: read with 2 wait cycles");
    r_delay = 2; rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b00;
    apply_stimulus(1'b0, 32'h04, 32'h0, 4'h0);
    wait_capture(cap);
    @(negedge i_axi_clk);
    check_output("t3_araddr", 64'(o_araddr), 64'h04);
    wait_rsp(20, r);
    check_output("t3_rsp_latency", 64'(r - cap), 64'd4);
    check_output("t3_rdata", 64'(o_rsp_rdata), 64'hDEADBEEF);
    check_output("t3_resp", 64'(o_rsp_resp), 64'd0);
    step();

    $display("[TB] test 4: read returning DECERR");
    r_delay = 0; rdata_cfg = 32'h0BADF00D; rresp_cfg = 2'b11;
    apply_stimulus(1'b0, 32'h08, 32'h0, 4'h0);
    wait_capture(cap);
    @(negedge i_axi_clk);
    check_output("t4_cmd_ready_low", 64'(o_cmd_ready), 64'd0);
    wait_rsp(20, r);
    check_output("t4_resp", 64'(o_rsp_resp), 64'd3);
    check_output("t4_cmd_ready_in_rsp", 64'(o_cmd_ready), 64'd0);
    rresp_cfg = 2'b00;
    step();

    $display("[TB] test 5: response back-pressure for 5 cycles");
    i_rsp_ready = 1'b0; bresp_cfg = 2'b01;
    apply_stimulus(1'b1, 32'h30, 32'hCAFEF00D, 4'h5);
    wait_capture(cap);
    wait_rsp(20, r);
    check_output("t5_resp", 64'(o_rsp_resp), 64'd1);
    for (int k = 1; k < 5; k++) begin
      step();
      if (k == 1) apply_stimulus(1'b0, 32'h44, 32'h0, 4'h0);
      @(negedge i_axi_clk);
      check_output("t5_hold_valid", 64'(o_rsp_valid), 64'd1);
      check_output("t5_hold_resp", 64'(o_rsp_resp), 64'd1);
      check_output("t5_refuse_cmd", 64'(o_cmd_ready), 64'd0);
    end
    step();
    i_rsp_ready = 1'b1; bresp_cfg = 2'b00; rdata_cfg = 32'h55AA55AA;
    wait_capture(cap);
    wait_rsp(20, r);
    check_output("t5_next_rdata", 64'(o_rsp_rdata), 64'h55AA55AA);
    step();

    $display("[TB] test 6: reset during write address/data phase");
    aw_delay = 100; w_delay = 100;
    apply_stimulus(1'b1, 32'h50, 32'h11112222, 4'hF);
    wait_capture(cap);
    @(negedge i_axi_clk);
    check_output("t6_valid_before_reset", 64'(o_awvalid), 64'd1);
    step();
    i_axi_rst = 1'b0;
    step();
    i_axi_rst = 1'b1;
    @(negedge i_axi_clk);
    check_output("t6_reset_outputs", 64'({o_awvalid, o_wvalid, o_cmd_ready}), 64'd0);
    aw_delay = 0; w_delay = 0;
    step();

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    $display("[TB] test 7: watchdog with silent slave");
    aw_delay = 1000; w_delay = 1000;
    apply_stimulus(1'b1, 32'h60, 32'h33334444, 4'hF);
    wait_capture(cap);
    wait_rsp(40, r);
    check_output("t7_timeout_latency", 64'(r - cap), 64'd16);
    check_output("t7_timeout_resp", 64'(o_rsp_resp), 64'd2);
    check_output("t7_timeout_rdata", 64'(o_rsp_rdata), 64'd0);
    aw_delay = 0; w_delay = 0;
    step();
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
